// File: rtl/buffer_register_ctrl_pkg.sv
// Shared types and defaults for the buffer_register sequencer/arbiter.
package buffer_register_ctrl_pkg;
  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/buffer_register_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the turn flag only moves when a grant is issued.
module rr_arb2 (
  input  logic clock,
  input  logic reset_n,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);
  // ser_turn_q is the last-served flag: it clears at reset so requester A wins the first tie
  logic ser_turn_q, ser_turn_d;

  always_comb begin
    gnt_a      = en && req_a && !(req_b && ser_turn_q);
    gnt_b      = en && req_b && !(req_a && !ser_turn_q);
    ser_turn_d = ser_turn_q;
    if (gnt_a)      ser_turn_d = 1'b1;
    else if (gnt_b) ser_turn_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ser_turn_q <= 1'b0;
    else          ser_turn_q <= ser_turn_d;
  end
endmodule

// File: rtl/buffer_register_ctrl.sv
// Sequences parallel loads / serial shift-ins into buffer_register and captures the word.
module buffer_register_ctrl
  import buffer_register_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             par_req,
  input  logic [WIDTH-1:0] par_data,
  output logic             par_gnt,
  input  logic             ser_req,
  input  logic             ser_bit,
  output logic             ser_gnt,
  output logic             buf_mode,
  output logic             buf_din_temp,
  output logic [WIDTH-1:0] buf_din,
  input  logic [WIDTH-1:0] buf_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             arb_en, gnt_par, gnt_ser;

  // A pending output word blocks arbitration, which creates the 1-cycle bubble after out_ready
  assign arb_en = (state_q == IDLE) && !out_valid_q;

  rr_arb2 u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (arb_en),
    .req_a   (par_req),
    .req_b   (ser_req),
    .gnt_a   (gnt_par),
    .gnt_b   (gnt_ser)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    par_gnt      = 1'b0;
    ser_gnt      = 1'b0;
    buf_mode     = 1'b0;
    buf_din_temp = 1'b0;
    buf_din      = '0;
    busy         = (state_q != IDLE);
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_par)      state_d = LOAD;
        else if (gnt_ser) state_d = SHIFT;
      end
      LOAD: begin
        par_gnt  = 1'b1;
        buf_mode = 1'b1;
        buf_din  = par_data;
        state_d  = DONE;
      end
      SHIFT: begin
        ser_gnt      = 1'b1;
        buf_din_temp = ser_bit;
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        // buf_dout already reflects the last LOAD/SHIFT edge here
        out_data_d  = buf_dout;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
endmodule

// File: tb/tb_buffer_register_ctrl.sv
// Bench for buffer_register_ctrl: transaction-level reference model plus a behavioural buffer_register.
module tb_buffer_register_ctrl;
  localparam int W = 4;

  logic         clock = 1'b0, reset_n = 1'b0;
  logic         par_req = 1'b0, ser_req = 1'b0, ser_bit = 1'b0, out_ready = 1'b0;
  logic [W-1:0] par_data = '0;
  logic         par_gnt, ser_gnt, buf_mode, buf_din_temp, out_valid, busy;
  logic [W-1:0] buf_din, buf_dout, out_data;
  logic [W-1:0] bufq = '0;

  int n_chk = 0, n_bad = 0;

  // Model: op 0 none / 1 parallel / 2 serial, k = cycle index inside the op (1-based)
  int           m_op, m_k, m_last, m_word;
  logic         m_valid;
  logic [W-1:0] m_data;
  int           glog[$];
  logic         pg_prev = 1'b0, sg_prev = 1'b0;

  buffer_register_ctrl #(.WIDTH(W)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .par_req      (par_req),
    .par_data     (par_data),
    .par_gnt      (par_gnt),
    .ser_req      (ser_req),
    .ser_bit      (ser_bit),
    .ser_gnt      (ser_gnt),
    .buf_mode     (buf_mode),
    .buf_din_temp (buf_din_temp),
    .buf_din      (buf_din),
    .buf_dout     (buf_dout),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (buf_mode) bufq <= buf_din;
    else          bufq <= {bufq[W-2:0], buf_din_temp};
  end
  assign buf_dout = bufq;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_op = 0; m_k = 0; m_last = -1; m_word = 0; m_valid = 1'b0; m_data = '0;
  endtask

  task automatic check_cycle();
    logic e_pg, e_sg;
    e_pg = (m_op == 1 && m_k == 1);
    e_sg = (m_op == 2 && m_k <= W);
    chk("par_gnt", par_gnt, e_pg);
    chk("ser_gnt", ser_gnt, e_sg);
    chk("buf_mode", buf_mode, e_pg);
    chk("buf_din", buf_din, e_pg ? par_data : '0);
    chk("buf_din_temp", buf_din_temp, e_sg ? ser_bit : 1'b0);
    chk("busy", busy, m_op != 0);
    chk("out_valid", out_valid, m_valid);
    chk("out_data", out_data, m_data);
    if (par_gnt && !pg_prev) glog.push_back(0);
    if (ser_gnt && !sg_prev) glog.push_back(1);
    pg_prev = par_gnt;
    sg_prev = ser_gnt;
  endtask

  // Called just after a rising edge; inputs still hold the values of the cycle that ended.
  task automatic model_update();
    if (m_op == 1) begin
      if (m_k == 1) begin m_word = int'(par_data); m_k = 2; end
      else begin m_valid = 1'b1; m_data = W'(m_word); m_op = 0; end
    end else if (m_op == 2) begin
      if (m_k <= W) begin m_word = (m_word * 2 + int'(ser_bit)) % (1 << W); m_k++; end
      else begin m_valid = 1'b1; m_data = W'(m_word); m_op = 0; end
    end else if (m_valid) begin
      if (out_ready) m_valid = 1'b0;
    end else if (par_req || ser_req) begin
      if (par_req && (!ser_req || m_last != 0)) begin m_op = 1; m_last = 0; end
      else begin m_op = 2; m_last = 1; end
      m_k = 1; m_word = 0;
    end
  endtask

  task automatic step();
    @(negedge clock);
    check_cycle();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic drop_reqs();
    if (m_op == 1 && m_k == 2) par_req = 1'b0;
    if (m_op == 2 && m_k >= 2) ser_req = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_par_gnt", par_gnt, 0);
    chk("rst_ser_gnt", ser_gnt, 0);
    chk("rst_buf_mode", buf_mode, 0);
    chk("rst_buf_din_temp", buf_din_temp, 0);
    chk("rst_buf_din", buf_din, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    model_reset();
    pg_prev = 1'b0; sg_prev = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic serial_word(input logic [W-1:0] sb, input string tag);
    for (int i = 0; i < W; i++) begin
      ser_bit = sb[W-1-i];
      chk({tag, "_ser_gnt"}, ser_gnt, 1);
      chk({tag, "_buf_mode"}, buf_mode, 0);
      step();
      drop_reqs();
    end
    ser_bit = 1'b0;
    step();
    chk({tag, "_out_valid"}, out_valid, 1);
    chk({tag, "_out_data"}, out_data, sb);
  endtask

  initial begin
    logic [W-1:0] w;
    model_reset();
    do_reset();
    chk("idle_busy", busy, 0);

    // Parallel load of 1101
    par_req = 1'b1; par_data = 4'b1101;
    step();
    chk("p_t1_par_gnt", par_gnt, 1);
    chk("p_t1_buf_din", buf_din, 4'b1101);
    step(); drop_reqs();
    step();
    chk("p_t3_out_valid", out_valid, 1);
    chk("p_t3_out_data", out_data, 4'b1101);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("p_ready_clears", out_valid, 0);

    // Serial shift-in of bits 1,0,1,1
    ser_req = 1'b1;
    step();
    w = 4'b1011;
    serial_word(w, "s");
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Both requests held from reset, consumer always ready
    ser_req = 1'b1; par_req = 1'b1; par_data = 4'b0110; out_ready = 1'b1;
    do_reset();
    glog.delete();
    for (int i = 0; i < 30; i++) begin ser_bit = 1'($urandom); step(); end
    chk("rr_cnt_ok", glog.size() >= 4, 1);
    if (glog.size() >= 4) begin
      chk("rr_g0", glog[0], 0); chk("rr_g1", glog[1], 1);
      chk("rr_g2", glog[2], 0); chk("rr_g3", glog[3], 1);
    end
    par_req = 1'b0; ser_req = 1'b0;
    for (int i = 0; i < 8; i++) step();

    // Backpressure: a held word blocks the next grant
    out_ready = 1'b0; par_req = 1'b1; par_data = 4'b0011;
    step(); step(); drop_reqs(); step();
    chk("bp_out_valid", out_valid, 1);
    par_req = 1'b1; par_data = 4'b1001;
    for (int i = 0; i < 4; i++) begin chk("bp_no_gnt", par_gnt, 0); step(); end
    out_ready = 1'b1;
    chk("bp_ready_cycle_gnt", par_gnt, 0);
    step(); out_ready = 1'b0;
    chk("bp_bubble_valid", out_valid, 0);
    chk("bp_bubble_gnt", par_gnt, 0);
    step();
    chk("bp_grant", par_gnt, 1);
    step(); drop_reqs(); step();
    chk("bp_word", out_data, 4'b1001);
    out_ready = 1'b1; step();

    // Reset in the middle of a serial shift (third SHIFT cycle, cnt = 2)
    ser_req = 1'b1;
    for (int i = 0; i < 20 && !(m_op == 2 && m_k == 3); i++) begin ser_bit = 1'($urandom); step(); end
    chk("mid_reached", (m_op == 2 && m_k == 3), 1);
    chk("mid_ser_gnt", ser_gnt, 1);
    #2;
    ser_req = 1'b1;
    do_reset();
    w = 4'b0110;
    serial_word(w, "rs");
    ser_req = 1'b0; out_ready = 1'b1; step();

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      drop_reqs();
      if (!par_req && m_op != 1 && $urandom_range(0, 3) == 0) begin
        par_req = 1'b1; par_data = W'($urandom);
      end
      if (!ser_req && m_op != 2 && $urandom_range(0, 3) == 0) ser_req = 1'b1;
      ser_bit   = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
